// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: passive receive-side observer of a VGA sync/colour stream. Recovers pixel x/y,
// checks line/frame timing, tracks lock and error count. Define VGA_MON_CRC_EN to build the per-frame CRC.
module vga_sync_monitor #(
    parameter int   H_TOTAL     = 800,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   H_ACTIVE    = 640,
    parameter int   V_TOTAL     = 525,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   V_ACTIVE    = 480,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0]  GOOD_NEED = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        vs_pend_q, vs_pend_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        locked_q, locked_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        hs_act, vs_act;
    logic        h_rise, h_fall, v_rise, v_fall;
    logic        frame_start;
    logic [10:0] hcnt_nxt, vcnt_nxt;
    logic        err_line, err_hwidth, err_frame, err_vwidth;
    logic        timing_err;
    logic        active;

    // Edge history stores "asserted" rather than raw pin level, so polarity is handled once here.
    assign hs_act = (hSync == SYNC_POL);
    assign vs_act = (vSync == SYNC_POL);
    assign h_rise = hs_act & ~hs_prev_q;
    assign h_fall = ~hs_act & hs_prev_q;
    assign v_rise = vs_act & ~vs_prev_q;
    assign v_fall = ~vs_act & vs_prev_q;

    // A vsync edge arms the frame start; the next hsync edge (possibly the same sample) fires it.
    assign frame_start = h_rise & (vs_pend_q | v_rise);

    assign hcnt_nxt = h_rise ? 11'd0 :
                      (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
    assign vcnt_nxt = frame_start ? 11'd0 :
                      !h_rise ? vcnt_q :
                      (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 11'd1;

    assign err_line   = h_rise & (hcnt_q != H_LAST);
    assign err_hwidth = h_fall & (hcnt_nxt != H_SYNC_W);
    assign err_frame  = frame_start & (vcnt_q != V_LAST);
    assign err_vwidth = v_fall & (vcnt_nxt != V_SYNC_W);
    assign timing_err = (state_q != ST_SEARCH) &
                        (err_line | err_hwidth | err_frame | err_vwidth);

    assign active = (hcnt_nxt >= H_ACT_LO) && (hcnt_nxt < H_ACT_HI) &&
                    (vcnt_nxt >= V_ACT_LO) && (vcnt_nxt < V_ACT_HI);

    always_comb begin
        state_d      = state_q;
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        vs_pend_d    = vs_pend_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        frame_done_d = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (pix_en) begin
            hs_prev_d    = hs_act;
            vs_prev_d    = vs_act;
            hcnt_d       = hcnt_nxt;
            vcnt_d       = vcnt_nxt;
            vs_pend_d    = frame_start ? 1'b0 : (vs_pend_q | v_rise);
            frame_done_d = frame_start;

            // An error in the same sample as a frame start takes priority.
            case (state_q)
                ST_SEARCH: begin
                    if (frame_start) begin
                        state_d    = ST_ALIGN;
                        good_cnt_d = 8'd0;
                    end
                end
                ST_ALIGN: begin
                    if (timing_err) begin
                        state_d = ST_SEARCH;
                    end else if (frame_start) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q + 8'd1 >= GOOD_NEED) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (timing_err) begin
                        state_d = ST_SEARCH;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase

            locked_d    = (state_d == ST_LOCKED);
            pix_valid_d = locked_d & active;
            if (active) begin
                pix_x_d   = 10'(hcnt_nxt - H_ACT_LO);
                pix_y_d   = 10'(vcnt_nxt - V_ACT_LO);
                pix_rgb_d = rgb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SEARCH;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            vs_pend_q    <= 1'b0;
            hcnt_q       <= 11'd0;
            vcnt_q       <= 11'd0;
            good_cnt_q   <= 8'd0;
            locked_q     <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 10'd0;
            pix_rgb_q    <= 12'd0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            vs_pend_q    <= vs_pend_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign frame_done = frame_done_q;
    assign err_cnt    = err_cnt_q;

`ifdef VGA_MON_CRC_EN
    // CRC-16-CCITT, MSB first, one 12-bit colour word per active sample.
    function automatic logic [15:0] crc12_step(input logic [15:0] crc_in, input logic [11:0] data);
        logic [15:0] r;
        r = crc_in;
        for (int i = 11; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        if (pix_en) begin
            if (frame_start) begin
                frame_crc_d = crc_q;
                crc_d       = 16'hFFFF;
            end else if (active) begin
                crc_d = crc12_step(crc_q, rgb);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

endmodule
